// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: sizes, instruction kinds and the entry layout.
package rob_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int unsigned ROB_SZ     = 16;
  localparam int unsigned ROB_SZ_LOG = 4;
  localparam int unsigned REG_SZ_LOG = 5;
  localparam int unsigned TAG_W      = ROB_SZ_LOG + 1;
  localparam int unsigned RD_W       = REG_SZ_LOG + 1;
  localparam int unsigned CNT_W      = ROB_SZ_LOG + 1;
  localparam int unsigned XLEN       = 32;

  typedef enum logic [2:0] {
    KIND_ALU    = 3'd0,
    KIND_BRANCH = 3'd1,
    KIND_JALR   = 3'd2,
    KIND_LOAD   = 3'd3,
    KIND_STORE  = 3'd4
  } kind_e;

  typedef struct packed {
    logic            busy;
    logic            ready;
    kind_e           kind;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] value;
    logic [XLEN-1:0] pc;
    logic            pred_jump;
    logic            jump;
    logic [XLEN-1:0] target;
  } rob_entry_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer: in-order allocate/commit circular queue with result broadcast,
// operand lookup with same-cycle forwarding, and flush on mispredict or jalr.
module rob
  import rob_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              run_add,
  input  logic [2:0]        in_kind,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              in_pred_jump,
  input  logic              in_ready,
  input  logic [XLEN-1:0]   in_val,
  input  logic              run_upd_alu,
  input  logic [TAG_W-1:0]  alu_rd,
  input  logic [XLEN-1:0]   alu_res,
  input  logic              alu_jump,
  input  logic [XLEN-1:0]   alu_target,
  input  logic              run_upd_lad,
  input  logic [TAG_W-1:0]  lad_rd,
  input  logic [XLEN-1:0]   lad_res,
  input  logic [TAG_W-1:0]  qj_tag,
  input  logic [TAG_W-1:0]  qk_tag,
  output logic              qj_rdy,
  output logic [XLEN-1:0]   qj_val,
  output logic              qk_rdy,
  output logic [XLEN-1:0]   qk_val,
  output logic [TAG_W-1:0]  ret_tag,
  output logic              ret_full,
  output logic              commit_flg,
  output logic [RD_W-1:0]   commit_rd,
  output logic [XLEN-1:0]   commit_val,
  output logic [TAG_W-1:0]  commit_tag,
  output logic              commit_store,
  output logic              reset,
  output logic [XLEN-1:0]   reset_pc
);

  rob_entry_t              ents [ROB_SZ];
  logic [ROB_SZ_LOG-1:0]   head;
  logic [ROB_SZ_LOG-1:0]   tail;
  logic [CNT_W-1:0]        count;

  logic do_add;
  logic do_commit;
  logic do_wr;
  logic do_store;
  logic do_flush;

  assign ret_tag  = TAG_W'(tail) + TAG_W'(1);
  assign ret_full = (count == CNT_W'(ROB_SZ));

  // Decode what the head entry does when it retires this cycle.
  always_comb begin
    do_add    = run_add && !ret_full;
    do_commit = ents[head].busy && ents[head].ready;
    do_wr     = LOW;
    do_store  = LOW;
    do_flush  = LOW;
    if (do_commit) begin
      case (ents[head].kind)
        KIND_ALU, KIND_LOAD: do_wr = (ents[head].rd != '0);
        KIND_JALR: begin
          do_wr    = (ents[head].rd != '0);
          do_flush = HIGH;
        end
        KIND_BRANCH: do_flush = (ents[head].jump != ents[head].pred_jump);
        KIND_STORE:  do_store = HIGH;
        default: ;
      endcase
    end
  end

  // Stored result first, then this cycle's broadcasts; tag 0 is always ready with value 0.
  function automatic logic [XLEN:0] lookup(input logic [TAG_W-1:0] tag);
    logic [ROB_SZ_LOG-1:0] idx;
    idx = ROB_SZ_LOG'(tag - TAG_W'(1));
    if (tag == '0)
      return {HIGH, XLEN'(0)};
    if (tag <= TAG_W'(ROB_SZ) && ents[idx].busy && ents[idx].ready)
      return {HIGH, ents[idx].value};
    if (run_upd_alu && alu_rd == tag)
      return {HIGH, alu_res};
    if (run_upd_lad && lad_rd == tag)
      return {HIGH, lad_res};
    return {LOW, XLEN'(0)};
  endfunction

  always_comb begin
    {qj_rdy, qj_val} = lookup(qj_tag);
    {qk_rdy, qk_val} = lookup(qk_tag);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ROB_SZ; i++) ents[i] <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_flg   <= LOW;
      commit_store <= LOW;
      reset        <= LOW;
      commit_rd    <= '0;
      commit_val   <= '0;
      commit_tag   <= '0;
      reset_pc     <= '0;
    end else if (rdy) begin
      commit_flg   <= do_wr;
      commit_store <= do_store;
      reset        <= do_flush;
      if (do_commit) begin
        commit_rd  <= ents[head].rd;
        commit_val <= ents[head].value;
        commit_tag <= TAG_W'(head) + TAG_W'(1);
      end
      if (do_flush) reset_pc <= ents[head].target;

      for (int i = 0; i < ROB_SZ; i++) begin
        if (ents[i].busy && run_upd_alu && alu_rd == TAG_W'(i + 1)) begin
          ents[i].ready  <= HIGH;
          ents[i].value  <= alu_res;
          ents[i].jump   <= alu_jump;
          ents[i].target <= alu_target;
        end
        if (ents[i].busy && run_upd_lad && lad_rd == TAG_W'(i + 1)) begin
          ents[i].ready <= HIGH;
          ents[i].value <= lad_res;
        end
      end

      if (do_flush) begin
        for (int i = 0; i < ROB_SZ; i++) ents[i].busy <= LOW;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_commit) begin
          ents[head].busy <= LOW;
          head            <= head + ROB_SZ_LOG'(1);
        end
        // Written after the broadcast loop so a new entry never picks up its own tag this cycle.
        if (do_add) begin
          ents[tail] <= '{busy: HIGH, ready: in_ready, kind: kind_e'(in_kind), rd: in_rd,
                          value: in_val, pc: in_pc, pred_jump: in_pred_jump, jump: LOW,
                          target: XLEN'(0)};
          tail       <= tail + ROB_SZ_LOG'(1);
        end
        count <= count + CNT_W'(do_add) - CNT_W'(do_commit);
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: expected retire pulses go into a scoreboard queue that a monitor drains.
module tb_rob;
  import rob_pkg::*;

  logic              clk = 1'b0;
  logic              rst, rdy, run_add;
  logic [2:0]        in_kind;
  logic [RD_W-1:0]   in_rd;
  logic [31:0]       in_pc, in_val;
  logic              in_pred_jump, in_ready;
  logic              run_upd_alu, alu_jump, run_upd_lad;
  logic [TAG_W-1:0]  alu_rd, lad_rd, qj_tag, qk_tag;
  logic [31:0]       alu_res, alu_target, lad_res;
  logic              qj_rdy, qk_rdy, ret_full, commit_flg, commit_store, reset;
  logic [31:0]       qj_val, qk_val, commit_val, reset_pc;
  logic [TAG_W-1:0]  ret_tag, commit_tag;
  logic [RD_W-1:0]   commit_rd;

  rob dut (
    .clk(clk), .rst(rst), .rdy(rdy), .run_add(run_add), .in_kind(in_kind), .in_rd(in_rd),
    .in_pc(in_pc), .in_pred_jump(in_pred_jump), .in_ready(in_ready), .in_val(in_val),
    .run_upd_alu(run_upd_alu), .alu_rd(alu_rd), .alu_res(alu_res), .alu_jump(alu_jump),
    .alu_target(alu_target), .run_upd_lad(run_upd_lad), .lad_rd(lad_rd), .lad_res(lad_res),
    .qj_tag(qj_tag), .qk_tag(qk_tag), .qj_rdy(qj_rdy), .qj_val(qj_val), .qk_rdy(qk_rdy),
    .qk_val(qk_val), .ret_tag(ret_tag), .ret_full(ret_full), .commit_flg(commit_flg),
    .commit_rd(commit_rd), .commit_val(commit_val), .commit_tag(commit_tag),
    .commit_store(commit_store), .reset(reset), .reset_pc(reset_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             flg;
    logic             st;
    logic             rs;
    logic [RD_W-1:0]  rd;
    logic [31:0]      val;
    logic [TAG_W-1:0] tag;
    logic [31:0]      pc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic flg, input logic st, input logic rs,
                              input logic [RD_W-1:0] rd, input logic [31:0] val,
                              input logic [TAG_W-1:0] tag, input logic [31:0] pc);
    exp_t e;
    e.flg = flg; e.st = st; e.rs = rs; e.rd = rd; e.val = val; e.tag = tag; e.pc = pc;
    return e;
  endfunction

  // Any pulse seen after an advancing edge must match the oldest expectation.
  initial begin : monitor
    logic adv;
    exp_t e;
    forever begin
      @(posedge clk);
      adv = rdy && rst;
      @(negedge clk);
      if (adv && rst && (commit_flg || commit_store || reset)) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", 32'({commit_flg, commit_store, reset}), 32'h0);
        end else begin
          e = sb.pop_front();
          chk("pulse_flg", 32'(commit_flg), 32'(e.flg));
          chk("pulse_store", 32'(commit_store), 32'(e.st));
          chk("pulse_reset", 32'(reset), 32'(e.rs));
          if (e.flg) begin
            chk("commit_rd", 32'(commit_rd), 32'(e.rd));
            chk("commit_val", commit_val, e.val);
            chk("commit_tag", 32'(commit_tag), 32'(e.tag));
          end
          if (e.rs) chk("reset_pc", reset_pc, e.pc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic idle_in();
    run_add = 0; in_kind = 0; in_rd = 0; in_pc = 0; in_pred_jump = 0; in_ready = 0; in_val = 0;
    run_upd_alu = 0; alu_rd = 0; alu_res = 0; alu_jump = 0; alu_target = 0;
    run_upd_lad = 0; lad_rd = 0; lad_res = 0; qj_tag = 0; qk_tag = 0;
  endtask

  task automatic step();
    @(negedge clk);
    idle_in();
  endtask

  task automatic add(input logic [2:0] k, input logic [RD_W-1:0] rd, input logic pj,
                     input logic rdy_i, input logic [31:0] v);
    run_add = 1; in_kind = k; in_rd = rd; in_pc = 32'h1000; in_pred_jump = pj;
    in_ready = rdy_i; in_val = v;
  endtask

  task automatic alu(input logic [TAG_W-1:0] t, input logic [31:0] r, input logic j,
                     input logic [31:0] tg);
    run_upd_alu = 1; alu_rd = t; alu_res = r; alu_jump = j; alu_target = tg;
  endtask

  task automatic lad(input logic [TAG_W-1:0] t, input logic [31:0] r);
    run_upd_lad = 1; lad_rd = t; lad_res = r;
  endtask

  initial begin : stim
    idle_in();
    rdy = 1; rst = 0;
    #1;
    chk("rst_commit_flg", 32'(commit_flg), 0);
    chk("rst_reset", 32'(reset), 0);
    chk("rst_ret_tag", 32'(ret_tag), 1);
    chk("rst_ret_full", 32'(ret_full), 0);
    chk("tag0_rdy", 32'(qk_rdy), 1);
    repeat (2) @(negedge clk);
    rst = 1;

    // Fill all 16 entries, then a 17th request must be dropped.
    for (int i = 1; i <= 16; i++) begin
      add(KIND_ALU, RD_W'(i), 0, 0, 0);
      #1;
      chk("fill_ret_tag", 32'(ret_tag), 32'(i));
      chk("fill_not_full", 32'(ret_full), 0);
      step();
    end
    chk("full_after_16", 32'(ret_full), 1);
    chk("full_ret_tag", 32'(ret_tag), 1);
    add(KIND_ALU, 6'd1, 0, 0, 0);
    step();
    chk("full_17th_ignored_full", 32'(ret_full), 1);
    chk("full_17th_ignored_tag", 32'(ret_tag), 1);
    qj_tag = 5'd16;
    #1 chk("lookup_not_ready", 32'(qj_rdy), 0);
    #1 rst = 0;
    #1 chk("async_rst_clears_count", 32'(ret_full), 0);
    @(negedge clk);
    rst = 1;
    idle_in();

    // ALU result commits one edge after it becomes ready.
    add(KIND_ALU, 6'd5, 0, 0, 0);
    #1 chk("alloc_tag1", 32'(ret_tag), 1);
    step();
    alu(5'd1, 32'h1234, 0, 0);
    sb.push_back(mk(1, 0, 0, 6'd5, 32'h1234, 5'd1, 0));
    step();
    chk("no_commit_on_ready_edge", 32'(commit_flg), 0);
    step();
    chk("commit_flg_pulse", 32'(commit_flg), 1);
    chk("commit_rd_5", 32'(commit_rd), 5);
    chk("commit_val_1234", commit_val, 32'h1234);
    step();
    chk("commit_flg_drops", 32'(commit_flg), 0);

    // Tags 2..6: lookup forwarding, dual broadcast, store, rd=0 suppression.
    add(KIND_ALU, 6'd7, 0, 0, 0);          step();
    add(KIND_LOAD, 6'd8, 0, 0, 0);         step();
    add(KIND_STORE, 6'd0, 0, 1, 32'hdead); step();
    add(KIND_ALU, 6'd9, 0, 0, 0);          step();
    add(KIND_ALU, 6'd0, 0, 1, 32'd9);      step();
    alu(5'd3, 32'd7, 0, 0);
    qj_tag = 5'd3; qk_tag = 5'd2;
    #1;
    chk("fwd_qj_rdy", 32'(qj_rdy), 1);
    chk("fwd_qj_val", qj_val, 7);
    chk("pending_qk_rdy", 32'(qk_rdy), 0);
    step();
    qj_tag = 5'd3; qk_tag = 5'd0;
    #1;
    chk("stored_qj_rdy", 32'(qj_rdy), 1);
    chk("stored_qj_val", qj_val, 7);
    chk("tag0_qk_rdy", 32'(qk_rdy), 1);
    chk("tag0_qk_val", qk_val, 0);
    step();
    alu(5'd2, 32'h22, 0, 0);
    lad(5'd5, 32'h55);
    sb.push_back(mk(1, 0, 0, 6'd7, 32'h22, 5'd2, 0));
    sb.push_back(mk(1, 0, 0, 6'd8, 32'd7, 5'd3, 0));
    sb.push_back(mk(0, 1, 0, 6'd0, 0, 5'd4, 0));
    sb.push_back(mk(1, 0, 0, 6'd9, 32'h55, 5'd5, 0));
    step();
    qj_tag = 5'd5;
    #1 chk("lad_stored_val", qj_val, 32'h55);
    repeat (8) step();
    chk("after_drain_ret_tag", 32'(ret_tag), 7);

    // Mispredicted branch flushes; the same-cycle allocation is lost.
    add(KIND_BRANCH, 6'd0, 0, 0, 0); step();
    add(KIND_ALU, 6'd3, 0, 1, 32'd1); step();
    alu(5'd7, 0, 1, 32'h100);
    step();
    add(KIND_ALU, 6'd4, 0, 1, 32'd2);
    sb.push_back(mk(0, 0, 1, 0, 0, 0, 32'h100));
    step();
    chk("flush_reset", 32'(reset), 1);
    chk("flush_reset_pc", reset_pc, 32'h100);
    chk("flush_ret_tag", 32'(ret_tag), 1);
    chk("flush_not_full", 32'(ret_full), 0);
    step();
    chk("flush_pulse_drops", 32'(reset), 0);
    repeat (3) step();

    // Correct branch retires silently; jalr writes link and redirects.
    add(KIND_BRANCH, 6'd0, 1, 0, 0); step();
    add(KIND_JALR, 6'd1, 0, 0, 0);   step();
    alu(5'd1, 0, 1, 32'h200);        step();
    alu(5'd2, 32'h44, 1, 32'h300);
    sb.push_back(mk(1, 0, 1, 6'd1, 32'h44, 5'd2, 32'h300));
    step();
    repeat (4) step();
    chk("jalr_flush_ret_tag", 32'(ret_tag), 1);

    // Full queue: commit frees a slot, then allocate and commit together.
    for (int i = 0; i < 16; i++) begin
      add(KIND_ALU, 6'd10, 0, 0, 0);
      step();
    end
    chk("refill_full", 32'(ret_full), 1);
    alu(5'd1, 32'ha1, 0, 0);
    sb.push_back(mk(1, 0, 0, 6'd10, 32'ha1, 5'd1, 0));
    step();
    alu(5'd2, 32'ha2, 0, 0);
    sb.push_back(mk(1, 0, 0, 6'd10, 32'ha2, 5'd2, 0));
    step();
    chk("freed_not_full", 32'(ret_full), 0);
    chk("wrap_reuse_tag1", 32'(ret_tag), 1);
    add(KIND_ALU, 6'd11, 0, 0, 0);
    alu(5'd3, 32'ha3, 0, 0);
    sb.push_back(mk(1, 0, 0, 6'd10, 32'ha3, 5'd3, 0));
    step();
    chk("alloc_commit_count_kept", 32'(ret_full), 0);
    chk("alloc_commit_ret_tag", 32'(ret_tag), 2);
    chk("last_commit_tag2", 32'(commit_tag), 2);

    // Stall with a ready head: nothing retires until rdy returns.
    rdy = 0;
    repeat (3) begin
      step();
      chk("stall_holds_tag", 32'(commit_tag), 2);
    end
    rdy = 1;
    step();
    chk("resume_commit_tag3", 32'(commit_tag), 3);

    // Asynchronous reset mid-run clears registered outputs at once.
    #2 rst = 0;
    #1;
    chk("midrst_commit_flg", 32'(commit_flg), 0);
    chk("midrst_commit_tag", 32'(commit_tag), 0);
    chk("midrst_commit_val", commit_val, 0);
    chk("midrst_commit_rd", 32'(commit_rd), 0);
    chk("midrst_ret_tag", 32'(ret_tag), 1);
    @(negedge clk);
    rst = 1;
    repeat (3) step();
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
